// File: rtl/ble_ctrl_types_pkg.sv
// Shared types and constants for the BLE control blocks: the AT sequencer
// state encoding, the ASCII bytes it recognises and its failure codes.
package ble_ctrl_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        WAIT_RESP,
        DONE,
        FAIL,
        HOLD
    } ble_seq_state_t;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_END = 8'h00;
    localparam logic [7:0] ASCII_O   = 8'h4F;
    localparam logic [7:0] ASCII_K   = 8'h4B;
    localparam logic [7:0] ASCII_E   = 8'h45;
    localparam logic [7:0] ASCII_R   = 8'h52;

    localparam logic [1:0] FAIL_NONE      = 2'b00;
    localparam logic [1:0] FAIL_ERROR     = 2'b01;
    localparam logic [1:0] FAIL_TIMEOUT   = 2'b10;
    localparam logic [1:0] FAIL_MALFORMED = 2'b11;

endpackage

// File: rtl/ble_at_sequencer_if.sv
// Command-memory, TX FIFO and RX byte paths seen by the AT sequencer.
interface ble_at_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              tx_full;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              rx_valid;
    logic [7:0]        rx_data;

    modport master (
        output mem_rd_en, mem_addr, tx_valid, tx_data,
        input  mem_data, tx_full, rx_valid, rx_data
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_valid, tx_data,
        output mem_data, tx_full, rx_valid, rx_data
    );
endinterface

// File: rtl/ble_at_sequencer_resp_matcher.sv
// Watches RX bytes for "OK" or "ER" and raises a sticky flag; whichever pair
// completes first wins until the sequencer clears both at the next command.
module ble_resp_matcher
    import ble_ctrl_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ok,
    output logic       err
);

    logic [7:0] prev_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok        <= 1'b0;
            err       <= 1'b0;
            prev_byte <= 8'h00;
        end else if (clear) begin
            ok        <= 1'b0;
            err       <= 1'b0;
            prev_byte <= 8'h00;
        end else if (enable && rx_valid) begin
            prev_byte <= rx_data;
            if (!ok && !err) begin
                if (prev_byte == ASCII_O && rx_data == ASCII_K) begin
                    ok <= 1'b1;
                end else if (prev_byte == ASCII_E && rx_data == ASCII_R) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ble_at_sequencer.sv
// Streams CR-terminated AT commands from memory into the TX FIFO, waits for
// an OK/ERROR reply with timeout and retries, and reports done or fail.
module ble_at_sequencer
    import ble_ctrl_types_pkg::*;
#(
    parameter int MEM_DEPTH      = 256,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               setting_up,
    output logic               setup_done,
    output logic               fail,
    output logic [1:0]         fail_code,
    output logic [7:0]         cmd_count,
    ble_at_sequencer_if.master bus
);

    localparam int ADDR_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    ble_seq_state_t     state, state_n;
    logic [ADDR_W-1:0]  addr, addr_n;
    logic [ADDR_W-1:0]  cmd_base, cmd_base_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [7:0]         byte_r, byte_n;
    logic [1:0]         fail_code_n;
    logic [7:0]         cmd_count_n;

    logic at_cmd_start;
    logic match_clear;
    logic match_en;
    logic resp_ok;
    logic resp_err;

    assign at_cmd_start = (addr == cmd_base);
    assign match_clear  = (state == LATCH) && at_cmd_start;
    assign match_en     = (state == SEND) || (state == WAIT_RESP);

    ble_resp_matcher u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (match_clear),
        .enable   (match_en),
        .rx_valid (bus.rx_valid),
        .rx_data  (bus.rx_data),
        .ok       (resp_ok),
        .err      (resp_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            cmd_base  <= '0;
            retry     <= '0;
            timer     <= '0;
            byte_r    <= 8'h00;
            fail_code <= FAIL_NONE;
            cmd_count <= 8'h00;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            cmd_base  <= cmd_base_n;
            retry     <= retry_n;
            timer     <= timer_n;
            byte_r    <= byte_n;
            fail_code <= fail_code_n;
            cmd_count <= cmd_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        cmd_base_n  = cmd_base;
        retry_n     = retry;
        timer_n     = timer;
        byte_n      = byte_r;
        fail_code_n = fail_code;
        cmd_count_n = cmd_count;

        // Losing the enable mid-run abandons it silently; results stay visible.
        if (!setting_up && (state inside {FETCH, LATCH, SEND, WAIT_RESP})) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (setting_up) begin
                        cmd_count_n = 8'h00;
                        fail_code_n = FAIL_NONE;
                        addr_n      = '0;
                        cmd_base_n  = '0;
                        retry_n     = '0;
                        state_n     = FETCH;
                    end
                end
                FETCH: state_n = LATCH;
                LATCH: begin
                    byte_n = bus.mem_data;
                    if (at_cmd_start && bus.mem_data == ASCII_END) begin
                        state_n = DONE;
                    end else begin
                        state_n = SEND;
                    end
                end
                SEND: begin
                    if (!bus.tx_full) begin
                        if (byte_r == ASCII_CR) begin
                            timer_n = '0;
                            state_n = WAIT_RESP;
                        end else if (addr == LAST_ADDR) begin
                            fail_code_n = FAIL_MALFORMED;
                            state_n     = FAIL;
                        end else begin
                            addr_n  = addr + 1'b1;
                            state_n = FETCH;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (timer != '1) begin
                        timer_n = timer + 1'b1;
                    end
                    if (resp_ok) begin
                        cmd_count_n = cmd_count + 8'd1;
                        retry_n     = '0;
                        if (addr == LAST_ADDR) begin
                            state_n = DONE;
                        end else begin
                            addr_n     = addr + 1'b1;
                            cmd_base_n = addr + 1'b1;
                            state_n    = FETCH;
                        end
                    end else if (resp_err || timer == TIMER_LAST) begin
                        if (retry < RETRY_LIMIT) begin
                            retry_n = retry + 1'b1;
                            addr_n  = cmd_base;
                            state_n = FETCH;
                        end else begin
                            fail_code_n = resp_err ? FAIL_ERROR : FAIL_TIMEOUT;
                            state_n     = FAIL;
                        end
                    end
                end
                DONE:    state_n = HOLD;
                FAIL:    state_n = HOLD;
                HOLD: begin
                    if (!setting_up) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en = (state == FETCH);
    assign bus.mem_addr  = addr;
    assign bus.tx_valid  = (state == SEND) && !bus.tx_full;
    assign bus.tx_data   = byte_r;
    assign setup_done    = (state == DONE);
    assign fail          = (state == FAIL);

endmodule
